histogram_v2: RTL and testbench
===============================

HISTOGRAM_V2 -- requirements
Module: histogram_v2

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning bin address width; NBINS = 2**ADDR_W.
REQ-002 SHALL have parameter CNT_W, default 16, meaning per-bin counter width.
REQ-003 SHALL have parameter RD_CLEAR, default 0, meaning 1 = a bin is zeroed when it is read.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rw  input  1  mode: 1 = read, 0 = acquire.
REQ-007 SHALL have port clear  input  1  one-cycle pulse that starts a memory clear sweep.
REQ-008 SHALL have port sample_valid  input  1  sample strobe, honoured only in acquire mode.
REQ-009 SHALL have port sample  input  ADDR_W  bin index to increment.
REQ-010 SHALL have port rd_en  input  1  read strobe, honoured only in read mode.
REQ-011 SHALL have port addr  input  ADDR_W  bin index to read.
REQ-012 SHALL have port data_out  output  CNT_W  count of the bin read.
REQ-013 SHALL have port data_valid  output  1  data_out valid for this cycle.
REQ-014 SHALL have port busy  output  1  clear sweep in progress; samples and reads are ignored.
REQ-015 SHALL have port sat  output  1  sticky flag: some bin has saturated.
REQ-016 SHALL have port total  output  32  number of samples accepted since the last clear.

Function
REQ-017 SHALL use FSM states IDLE, CLEAR, ACQ and READ; IDLE->ACQ when rw=0, IDLE->READ when rw=1, ACQ<->READ when rw changes, and CLEAR is entered from any state on clear.
REQ-018 In CLEAR, SHALL write zero to addresses 0..NBINS-1, one per cycle, so busy stays high for exactly NBINS cycles and the FSM then goes to IDLE.
REQ-019 On entering CLEAR, SHALL zero total and sat.
REQ-020 SHALL accept a sample when state=ACQ and sample_valid=1.
REQ-021 SHALL update a bin through a 2-stage read-modify-write: RAM read at acceptance cycle N, incremented value written at edge N+1, visible to a read issued at N+2 or later.
REQ-022 When back-to-back samples hit the same bin, SHALL forward the pending write value so that no increment is lost; one sample per cycle is sustained with no stalls.
REQ-023 SHALL saturate counters at 2**CNT_W-1; an increment of a saturated bin leaves the value unchanged and sets sat.
REQ-024 SHALL increment total on every accepted sample, saturating at 2**32-1.
REQ-025 In READ, rd_en at cycle N SHALL give data_out = mem[addr] with data_valid=1 in cycle N+1; at all other times data_valid=0 and data_out holds its value.
REQ-026 With RD_CLEAR=1, SHALL write zero to the bin in the same cycle data_valid is asserted.
REQ-027 If rw switches ACQ->READ with an increment still in flight, SHALL complete that increment before any read and SHALL NOT return a pre-increment value.
REQ-028 SHALL ignore sample_valid while rw=1, rd_en while rw=0, and both while busy=1.
REQ-029 A clear pulse arriving during CLEAR SHALL restart the sweep at address 0.

Reset
REQ-030 rst SHALL take priority over all other inputs.
REQ-031 rst SHALL set data_out=0, data_valid=0, sat=0, total=0 and flush the pipeline.
REQ-032 rst SHALL enter CLEAR, so busy=1 for NBINS cycles after reset release and memory contents are defined.
REQ-033 rst asserted mid-sweep or mid-increment SHALL discard the operation and restart the sweep.

Structure
REQ-034 SHALL place FSM state encodings and default ADDR_W/CNT_W constants in shared package histogram_pkg.
REQ-035 SHALL instantiate one sub-module histogram_ram: simple dual-port RAM, NBINS x CNT_W, synchronous read, one write port, no reset of contents.

Verification
REQ-036 Reset, then poll busy -> busy=1 for exactly 256 cycles; a read of every bin then returns 0.
REQ-037 Acquire samples 5,5,5,7 on consecutive cycles, then read bins 5 and 7 -> 3 and 1, total=4.
REQ-038 CNT_W=4, 17 samples to bin 0 -> bin 0 reads 15, sat=1, total=17.
REQ-039 RD_CLEAR=1: bin 9 holds 2, read it twice -> 2 then 0.
REQ-040 Sample to bin 3 at cycle N, rw=1 at N+1, rd_en addr=3 at N+1 -> data_valid with value 1, no stale 0.
REQ-041 clear pulse mid-acquisition, then sample_valid during busy -> samples are ignored, total=0, all bins read 0 after the sweep.

Source files
------------

// File: rtl/histogram_pkg.sv
// Shared constants, FSM encoding and helpers for the histogram block.
package histogram_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned TOTAL_W    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACQ   = 2'd2,
        S_READ  = 2'd3
    } state_e;

    // Saturating increment for the accepted-sample counter.
    function automatic logic [TOTAL_W-1:0] sat_inc_total(input logic [TOTAL_W-1:0] v);
        return (v == '1) ? v : v + TOTAL_W'(1);
    endfunction

endpackage

// File: rtl/histogram_ram.sv
// Simple dual-port bin memory: one write port, one synchronous read port, no content reset.
module histogram_ram
    import histogram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CNT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CNT_W-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [CNT_W-1:0] mem_q [DEPTH];

    // Read-first: a same-address write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/histogram_v2.sv
// Histogram engine: pipelined saturating bin increments, readback with optional
// read-clear, and a one-bin-per-cycle clear sweep.
module histogram_v2
    import histogram_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned RD_CLEAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rw,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] sample,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              sat,
    output logic [31:0]       total
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
    logic                 inc_vld_q, inc_vld_d;
    logic [ADDR_W-1:0]    inc_addr_q, inc_addr_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]     wr_data_q, wr_data_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic                 sat_q, sat_d;
    logic [TOTAL_W-1:0]   total_q, total_d;

    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_waddr;
    logic [CNT_W-1:0]     ram_wdata;
    logic [ADDR_W-1:0]    ram_raddr;
    logic [CNT_W-1:0]     ram_rdata;

    logic                 accept_s;
    logic                 accept_r;
    logic [CNT_W-1:0]     inc_base;
    logic [CNT_W-1:0]     inc_val;
    logic [CNT_W-1:0]     rd_fresh;

    histogram_ram #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (ram_raddr),
        .rdata  (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        inc_vld_d  = 1'b0;
        inc_addr_d = inc_addr_q;
        rd_vld_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        hold_d     = hold_q;
        sat_d      = sat_q;
        total_d    = total_q;
        ram_we     = 1'b0;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;
        ram_raddr  = addr;

        accept_s = (state_q == S_ACQ) && !rw && sample_valid && !clear;
        accept_r = (state_q != S_CLEAR) && rw && rd_en && !clear;

        // The RAM is read-first, so the write committed last cycle is forwarded.
        inc_base = (wr_vld_q && (wr_addr_q == inc_addr_q)) ? wr_data_q : ram_rdata;
        rd_fresh = (wr_vld_q && (wr_addr_q == rd_addr_q))  ? wr_data_q : ram_rdata;
        inc_val  = (inc_base == CNT_MAX) ? inc_base : inc_base + CNT_W'(1);

        case (state_q)
            S_CLEAR: begin
                if (clr_addr_q == '1) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = rw ? S_READ : S_ACQ;
        endcase

        if (accept_s) begin
            ram_raddr  = sample;
            inc_vld_d  = 1'b1;
            inc_addr_d = sample;
            total_d    = sat_inc_total(total_q);
        end

        if (accept_r) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = addr;
        end

        if (rd_vld_q) begin
            hold_d = rd_fresh;
        end

        // Write port priority: sweep over increment over read-clear.
        if ((RD_CLEAR != 0) && rd_vld_q) begin
            ram_we    = 1'b1;
            ram_waddr = rd_addr_q;
            ram_wdata = '0;
        end
        if (inc_vld_q) begin
            ram_we    = 1'b1;
            ram_waddr = inc_addr_q;
            ram_wdata = inc_val;
            if (inc_base == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
        if (state_q == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
        if (rst) begin
            ram_we = 1'b0;
        end

        if (clear) begin
            state_d    = S_CLEAR;
            clr_addr_d = '0;
            total_d    = '0;
            sat_d      = 1'b0;
        end

        wr_vld_d  = ram_we;
        wr_addr_d = ram_waddr;
        wr_data_d = ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            inc_vld_q  <= 1'b0;
            inc_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= '0;
            sat_q      <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            inc_vld_q  <= inc_vld_d;
            inc_addr_q <= inc_addr_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            wr_vld_q   <= wr_vld_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            sat_q      <= sat_d;
            total_q    <= total_d;
        end
    end

    assign busy       = (state_q == S_CLEAR);
    assign data_valid = rd_vld_q;
    assign data_out   = rd_vld_q ? rd_fresh : hold_q;
    assign sat        = sat_q;
    assign total      = total_q;

endmodule

// File: tb/tb_histogram_v2.sv
// Directed bench for histogram_v2: default, 4-bit-counter and read-clear instances share stimulus.
module tb_histogram_v2;

    logic        clk;
    logic        rst;
    logic        rw;
    logic        clear;
    logic        sample_valid;
    logic [7:0]  sample;
    logic        rd_en;
    logic [7:0]  addr;

    logic [15:0] d0;
    logic        dv0, busy0, sat0;
    logic [31:0] tot0;
    logic [3:0]  ds;
    logic        dvs, busys, sats;
    logic [31:0] tots;
    logic [15:0] dr;
    logic        dvr, busyr, satr;
    logic [31:0] totr;

    int checks = 0;
    int errors = 0;

    histogram_v2 dut (
        .clk(clk), .rst(rst), .rw(rw), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .rd_en(rd_en), .addr(addr), .data_out(d0), .data_valid(dv0),
        .busy(busy0), .sat(sat0), .total(tot0)
    );

    histogram_v2 #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .rw(rw), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .rd_en(rd_en), .addr(addr), .data_out(ds), .data_valid(dvs),
        .busy(busys), .sat(sats), .total(tots)
    );

    histogram_v2 #(.RD_CLEAR(1)) dut_rc (
        .clk(clk), .rst(rst), .rw(rw), .clear(clear), .sample_valid(sample_valid),
        .sample(sample), .rd_en(rd_en), .addr(addr), .data_out(dr), .data_valid(dvr),
        .busy(busyr), .sat(satr), .total(totr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        int n;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin
            n++;
            cyc();
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL clear_timeout busy still high after %0d cycles", n);
        end
    endtask

    task automatic start_acq();
        rw = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic send(input logic [7:0] a);
        sample_valid = 1'b1;
        sample       = a;
        cyc();
        sample_valid = 1'b0;
    endtask

    // Issues one read; on return the data_valid cycle is current.
    task automatic read_bin(input logic [7:0] a);
        rw    = 1'b1;
        rd_en = 1'b1;
        addr  = a;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({dv0, d0, sat0, tot0, busy0} !== {1'b0, 16'd0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got dv=%0b d=%0d sat=%0b tot=%0d busy=%0b want 0 0 0 0 1",
                     dv0, d0, sat0, tot0, busy0);
        end
        checks++;
        if ({sats, tots, satr, totr, busys, busyr} !== {1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_state_variants got sat=%0b/%0b tot=%0d/%0d busy=%0b/%0b",
                     sats, satr, tots, totr, busys, busyr);
        end
        rst = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin
            n++;
            cyc();
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL reset_busy_len got %0d want 256", n);
        end
        for (int a = 0; a < 256; a++) begin
            read_bin(8'(a));
            checks++;
            if ({dv0, d0, dvr, dr} !== {1'b1, 16'd0, 1'b1, 16'd0}) begin
                errors++;
                $display("FAIL reset_bin_zero bin %0d got dv=%0b d=%0d rc=%0d want 1 0 0", a, dv0, d0, dr);
            end
        end
    endtask

    task automatic test_basic();
        do_clear();
        start_acq();
        send(8'd5);
        send(8'd5);
        send(8'd5);
        send(8'd7);
        checks++;
        if (tot0 !== 32'd4) begin
            errors++;
            $display("FAIL basic_total got %0d want 4", tot0);
        end
        read_bin(8'd5);
        checks++;
        if ({dv0, d0, ds} !== {1'b1, 16'd3, 4'd3}) begin
            errors++;
            $display("FAIL basic_bin5 got dv=%0b d=%0d ds=%0d want 1 3 3", dv0, d0, ds);
        end
        read_bin(8'd7);
        checks++;
        if ({dv0, d0, dr} !== {1'b1, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL basic_bin7 got dv=%0b d=%0d rc=%0d want 1 1 1", dv0, d0, dr);
        end
        cyc();
        cyc();
        checks++;
        if ({dv0, d0} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL basic_hold got dv=%0b d=%0d want 0 1", dv0, d0);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        start_acq();
        for (int i = 0; i < 17; i++) send(8'd0);
        cyc();
        checks++;
        if ({sats, tots} !== {1'b1, 32'd17}) begin
            errors++;
            $display("FAIL sat_flags got sat=%0b tot=%0d want 1 17", sats, tots);
        end
        checks++;
        if ({sat0, tot0} !== {1'b0, 32'd17}) begin
            errors++;
            $display("FAIL sat_wide_flags got sat=%0b tot=%0d want 0 17", sat0, tot0);
        end
        read_bin(8'd0);
        checks++;
        if ({dvs, ds, d0} !== {1'b1, 4'd15, 16'd17}) begin
            errors++;
            $display("FAIL sat_bin0 got dv=%0b ds=%0d d=%0d want 1 15 17", dvs, ds, d0);
        end
    endtask

    task automatic test_rd_clear();
        do_clear();
        start_acq();
        send(8'd9);
        send(8'd9);
        cyc();
        read_bin(8'd9);
        checks++;
        if ({dvr, dr, d0} !== {1'b1, 16'd2, 16'd2}) begin
            errors++;
            $display("FAIL rdclr_first got dv=%0b rc=%0d d=%0d want 1 2 2", dvr, dr, d0);
        end
        read_bin(8'd9);
        checks++;
        if ({dvr, dr, d0} !== {1'b1, 16'd0, 16'd2}) begin
            errors++;
            $display("FAIL rdclr_second got dv=%0b rc=%0d d=%0d want 1 0 2", dvr, dr, d0);
        end
    endtask

    task automatic test_inflight();
        do_clear();
        start_acq();
        sample_valid = 1'b1;
        sample       = 8'd3;
        cyc();
        sample_valid = 1'b0;
        rw    = 1'b1;
        rd_en = 1'b1;
        addr  = 8'd3;
        cyc();
        rd_en = 1'b0;
        checks++;
        if ({dv0, d0} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL inflight_read got dv=%0b d=%0d want 1 1", dv0, d0);
        end
        sample_valid = 1'b1;
        cyc();
        cyc();
        sample_valid = 1'b0;
        checks++;
        if (tot0 !== 32'd1) begin
            errors++;
            $display("FAIL ignore_sample_in_read got tot=%0d want 1", tot0);
        end
        rw = 1'b0;
        cyc();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (dv0 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_rd_in_acq got dv=%0b want 0", dv0);
        end
        read_bin(8'd3);
        checks++;
        if ({dv0, d0} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL inflight_reread got dv=%0b d=%0d want 1 1", dv0, d0);
        end
    endtask

    task automatic test_clear_busy();
        int n;
        do_clear();
        start_acq();
        send(8'd2);
        send(8'd2);
        send(8'd2);
        checks++;
        if (tot0 !== 32'd3) begin
            errors++;
            $display("FAIL pre_clear_total got %0d want 3", tot0);
        end
        clear        = 1'b1;
        sample_valid = 1'b1;
        sample       = 8'd2;
        cyc();
        clear = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin
            n++;
            cyc();
        end
        sample_valid = 1'b0;
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL clear_busy_len got %0d want 256", n);
        end
        checks++;
        if ({tot0, sat0} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear_total got tot=%0d sat=%0b want 0 0", tot0, sat0);
        end
        for (int a = 0; a < 256; a++) begin
            read_bin(8'(a));
            checks++;
            if ({dv0, d0} !== {1'b1, 16'd0}) begin
                errors++;
                $display("FAIL clear_bin_zero bin %0d got dv=%0b d=%0d want 1 0", a, dv0, d0);
            end
        end
    endtask

    task automatic test_restart();
        int n;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 100; i++) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin
            n++;
            cyc();
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL restart_busy_len got %0d want 256", n);
        end
    endtask

    initial begin
        rst          = 1'b1;
        rw           = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        rd_en        = 1'b0;
        addr         = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_rd_clear();
        test_inflight();
        test_clear_busy();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
